// File: rtl/leaf_elimination_iterative.sv
// Iterative leaf eliminator over the Boolean lattice of VARIABLES variables.
// Optional macro LEAF_ELIMINATION_STATS_EN adds the out_removed vertex-count port.
module leaf_elimination_iterative #(
    parameter int VARIABLES = 7,
    parameter int MAX_ITER  = 16,
    parameter int PW        = $clog2(MAX_ITER + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [(1<<VARIABLES)-1:0]   in_graph,
    input  logic [1:0]                  in_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [(1<<VARIABLES)-1:0]   out_graph,
    output logic [PW-1:0]               out_passes,
    output logic                        out_truncated
`ifdef LEAF_ELIMINATION_STATS_EN
    ,
    output logic [VARIABLES:0]          out_removed
`endif
);
    localparam int W = 1 << VARIABLES;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  work;
    logic          altMode;
    logic          dirUp;
    logic [PW-1:0] passCount;
    logic [1:0]    quietCount;
    logic          truncated;

    logic [W-1:0]  nextGraph;
    logic          changed;
    logic [PW-1:0] nextPass;
    logic [1:0]    nextQuiet;
    logic          fixpoint;
    logic          capHit;

    // One elimination pass; every vertex is judged against the unmodified input.
    function automatic logic [W-1:0] leafPass(input logic [W-1:0] g, input logic upDir);
        logic [W-1:0]         r;
        logic [VARIABLES-1:0] nb;
        logic [VARIABLES-1:0] self;
        int                   upCnt;
        int                   dnCnt;
        r = g;
        for (int i = 1; i < W - 1; i++) begin
            upCnt = 0;
            dnCnt = 0;
            self  = VARIABLES'(i);
            for (int b = 0; b < VARIABLES; b++) begin
                nb = VARIABLES'(i ^ (1 << b));
                if (((i >> b) & 1) != 0)
                    dnCnt += int'(g[nb]);
                else
                    upCnt += int'(g[nb]);
            end
            if (upDir) begin
                if (dnCnt == 1 && upCnt == 0)
                    r[self] = 1'b0;
            end else if (upCnt == 1 && dnCnt == 0) begin
                r[self] = 1'b0;
            end
        end
        return r;
    endfunction

`ifdef LEAF_ELIMINATION_STATS_EN
    logic [VARIABLES:0] inPop;
    logic [VARIABLES:0] removed;

    function automatic logic [VARIABLES:0] popCount(input logic [W-1:0] g);
        logic [VARIABLES:0] c;
        logic [W-1:0]       t;
        c = '0;
        t = g;
        for (int i = 0; i < W; i++) begin
            c = c + {{VARIABLES{1'b0}}, t[0]};
            t = t >> 1;
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            inPop   <= '0;
            removed <= '0;
        end else if (state == IDLE && in_valid) begin
            inPop <= popCount(in_graph);
        end else if (state == RUN && (fixpoint || capHit)) begin
            removed <= inPop - popCount(nextGraph);
        end
    end

    assign out_removed = removed;
`endif

    always_comb begin
        nextGraph = leafPass(work, dirUp);
        changed   = (nextGraph != work);
        nextPass  = passCount + PW'(1);
        nextQuiet = changed ? 2'd0 : quietCount + 2'd1;
        fixpoint  = altMode ? (nextQuiet == 2'd2) : !changed;
        capHit    = (nextPass == PW'(MAX_ITER));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            work       <= '0;
            altMode    <= 1'b0;
            dirUp      <= 1'b0;
            passCount  <= '0;
            quietCount <= '0;
            truncated  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work       <= in_graph;
                        altMode    <= in_mode[1];
                        dirUp      <= (in_mode == 2'd1);
                        passCount  <= '0;
                        quietCount <= '0;
                        truncated  <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    work       <= nextGraph;
                    passCount  <= nextPass;
                    quietCount <= nextQuiet;
                    if (altMode)
                        dirUp <= ~dirUp;
                    // A fixpoint reached on the capping pass is not a truncation.
                    if (fixpoint) begin
                        state <= DONE;
                    end else if (capHit) begin
                        state     <= DONE;
                        truncated <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state == IDLE);
    assign out_valid     = (state == DONE);
    assign out_graph     = work;
    assign out_passes    = passCount;
    assign out_truncated = truncated;

endmodule
